fp_sqrt_prep: RTL and testbench

FP_SQRT_PREP -- requirements
Module: fp_sqrt_prep

---
 rtl/fp_sqrt_pkg.sv | 18 +
 rtl/fp_sqrt_lzc.sv | 16 +
 rtl/fp_sqrt_prep.sv | 165 ++++++++++++++++
 tb/tb_fp_sqrt_prep.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_sqrt_pkg.sv
// Shared types and IEEE-754 single constants for the square-root front end.
// Denormal normalisation support is selected by FP_SQRT_DENORM_EN (see fp_sqrt_prep).
package fp_sqrt_pkg;

  localparam logic [7:0]  FP_BIAS = 8'd127;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP_PINF = 32'h7F80_0000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLASSIFY  = 3'd1,
    ST_NORM      = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_SPECIAL   = 3'd5
  } state_e;

endpackage : fp_sqrt_pkg

// File: rtl/fp_sqrt_lzc.sv
// 23-bit leading-zero counter for denormal fractions (combinational).
// Only instantiated when FP_SQRT_DENORM_EN is defined. An all-zero input reports 23.
module fp_sqrt_lzc (
  input  logic [22:0] value_i,
  output logic [4:0]  count_o
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    count_o = 5'd23;
    for (int i = 0; i < 23; i++) begin
      if (value_i[i]) count_o = 5'(22 - i);
    end
  end

endmodule : fp_sqrt_lzc

// File: rtl/fp_sqrt_prep.sv
// Square-root operand preparation: classifies an IEEE-754 single radicand,
// resolves special cases locally and hands aligned mantissa/exponent to the core.
// Build option: FP_SQRT_DENORM_EN -- normalise positive denormals instead of
// flushing them to a signed zero.
//
// state        | meaning
// -------------+--------------------------------------------------------
// ST_IDLE      | ready for an operand, in_ready high
// ST_CLASSIFY  | decode captured operand, pick special or normal path
// ST_NORM      | denormal alignment via leading-zero count (option only)
// ST_ISSUE     | one-cycle core_start with core_data/core_exp valid
// ST_WAIT_DONE | hold core operands until core_done
// ST_SPECIAL   | one-cycle special_valid with special_data
module fp_sqrt_prep
  import fp_sqrt_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  core_start,
  output logic [DATA_WIDTH-1:0] core_data,
  output logic [7:0]            core_exp,
  input  logic                  core_done,
  output logic                  special_valid,
  output logic [DATA_WIDTH-1:0] special_data,
  output logic                  busy
);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH-1:0]   core_data_q, core_data_d;
  logic [7:0]              core_exp_q, core_exp_d;
  logic [DATA_WIDTH-1:0]   special_data_q, special_data_d;

  logic                    sgn;
  logic [7:0]              exp_f;
  logic [22:0]             frac;
  logic                    is_zero, is_nan, is_inf, is_denorm;
  logic [7:0]              nm_exp;
  logic [DATA_WIDTH-1:0]   nm_word;

  assign sgn       = data_q[31];
  assign exp_f     = data_q[30:23];
  assign frac      = data_q[22:0];
  assign is_zero   = (exp_f == 8'd0)   && (frac == 23'd0);
  assign is_denorm = (exp_f == 8'd0)   && (frac != 23'd0);
  assign is_nan    = (exp_f == 8'hFF)  && (frac != 23'd0);
  assign is_inf    = (exp_f == 8'hFF)  && (frac == 23'd0);

  // Normal operand: halve the unbiased exponent, odd biased exponent keeps the
  // mantissa in place, even one pre-shifts so the core sees an even exponent.
  assign nm_exp  = 8'(({1'b0, exp_f} + 9'd1) >> 1) + {1'b0, FP_BIAS[7:1]};
  assign nm_word = exp_f[0] ? {8'b0, 1'b1, frac} : {7'b0, 1'b1, frac, 1'b0};

`ifdef FP_SQRT_DENORM_EN
  logic [4:0]              lz;
  logic [23:0]             dn_mant;
  logic [7:0]              dn_exp;
  logic [DATA_WIDTH-1:0]   dn_word;

  fp_sqrt_lzc u_lzc (
    .value_i (frac),
    .count_o (lz)
  );

  // Shifting the leading one up to bit 23 restores it as the hidden bit.
  assign dn_mant = {1'b0, frac} << (lz + 5'd1);
  assign dn_exp  = FP_BIAS - 8'd64 - {4'b0, lz[4:1]};
  assign dn_word = lz[0] ? {8'b0, dn_mant} : {7'b0, dn_mant, 1'b0};
`endif

  // Next-state and output-register update for the sequencing FSM.
  always_comb begin
    state_d        = state_q;
    core_data_d    = core_data_q;
    core_exp_d     = core_exp_q;
    special_data_d = special_data_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) state_d = ST_CLASSIFY;
      end
      ST_CLASSIFY: begin
        if (is_zero) begin
          state_d        = ST_SPECIAL;
          special_data_d = data_q;
        end else if (is_nan) begin
          state_d        = ST_SPECIAL;
          special_data_d = FP_QNAN;
        end else if (is_denorm) begin
`ifdef FP_SQRT_DENORM_EN
          if (sgn) begin
            state_d        = ST_SPECIAL;
            special_data_d = FP_QNAN;
          end else begin
            state_d = ST_NORM;
          end
`else
          state_d        = ST_SPECIAL;
          special_data_d = {sgn, 31'b0};
`endif
        end else if (sgn) begin
          state_d        = ST_SPECIAL;
          special_data_d = FP_QNAN;
        end else if (is_inf) begin
          state_d        = ST_SPECIAL;
          special_data_d = FP_PINF;
        end else begin
          state_d     = ST_ISSUE;
          core_data_d = nm_word;
          core_exp_d  = nm_exp;
        end
      end
      ST_NORM: begin
`ifdef FP_SQRT_DENORM_EN
        state_d     = ST_ISSUE;
        core_data_d = dn_word;
        core_exp_d  = dn_exp;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_ISSUE:     state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (core_done) state_d = ST_IDLE;
      ST_SPECIAL:   state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // State and result registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      core_data_q    <= '0;
      core_exp_q     <= '0;
      special_data_q <= '0;
    end else begin
      state_q        <= state_d;
      core_data_q    <= core_data_d;
      core_exp_q     <= core_exp_d;
      special_data_q <= special_data_d;
    end
  end

  // Operand capture on the accept handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (in_valid && in_ready) begin
      data_q <= in_data;
    end
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign core_start    = (state_q == ST_ISSUE);
  assign special_valid = (state_q == ST_SPECIAL);
  assign core_data     = core_data_q;
  assign core_exp      = core_exp_q;
  assign special_data  = special_data_q;

endmodule : fp_sqrt_prep

// File: tb/tb_fp_sqrt_prep.sv
// Scoreboard bench for fp_sqrt_prep: directed radicands with hand-computed
// results; expectations honour FP_SQRT_DENORM_EN when it is defined.
module tb_fp_sqrt_prep;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        core_start;
  logic [31:0] core_data;
  logic [7:0]  core_exp;
  logic        core_done;
  logic        special_valid;
  logic [31:0] special_data;
  logic        busy;

  always #5 clk = ~clk;

  fp_sqrt_prep #(.DATA_WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .core_start    (core_start),
    .core_data     (core_data),
    .core_exp      (core_exp),
    .core_done     (core_done),
    .special_valid (special_valid),
    .special_data  (special_data),
    .busy          (busy)
  );

  typedef struct {
    logic        sp;
    logic [31:0] data;
    logic [7:0]  exp;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          edge_n   = 0;
  int          acc_edge = 0;
  int          accepts  = 0;
  int          cur_lat  = 2;
  logic        in_wait  = 1'b0;
  logic        stab_err = 1'b0;
  logic [31:0] held_data;
  logic [7:0]  held_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  always @(posedge clk) edge_n <= edge_n + 1;

  // Monitor: samples on the falling edge, pops the scoreboard on every output event.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      in_wait  = 1'b0;
      stab_err = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        acc_edge = edge_n + 1;
        accepts++;
      end
      if (core_start) begin
        if (sb_q.size() == 0) begin
          check("unexpected_core_start", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("path_is_special", 32'(0), 32'(e.sp));
          check("core_data", core_data, e.data);
          check("core_exp", 32'(core_exp), 32'(e.exp));
          check("start_latency", 32'((edge_n + 1) - acc_edge), 32'(e.lat));
          held_data = core_data;
          held_exp  = core_exp;
          in_wait   = 1'b1;
          stab_err  = 1'b0;
        end
      end else if (in_wait) begin
        if (core_data !== held_data || core_exp !== held_exp) stab_err = 1'b1;
        if (core_done) begin
          check("operand_hold", 32'(stab_err), 32'd0);
          in_wait = 1'b0;
        end
      end
      if (special_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_special", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("path_is_special", 32'd1, 32'(e.sp));
          check("special_data", special_data, e.data);
          check("no_start_on_special", 32'(core_start), 32'd0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (!core_start && n < 20) begin step(); n++; end
    if (n >= 20) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic run_op(input logic [31:0] d, input logic sp, input logic [31:0] ed,
                        input logic [7:0] ee, input int lat, input int dly);
    int n = 0;
    sb_q.push_back('{sp, ed, ee, lat});
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 20) begin step(); n++; end
    step();
    in_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    if (!sp) begin
      wait_start("core_start");
      repeat (dly) step();
      core_done = 1'b1;
      step();
      core_done = 1'b0;
    end else begin
      n = 0;
      while (!special_valid && n < 20) begin step(); n++; end
      if (n >= 20) check("special_timeout", 32'd1, 32'd0);
      step();
    end
    check("ready_after_op", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    core_done = 1'b0;
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_special_valid", 32'(special_valid), 32'd0);
    check("rst_core_data", core_data, 32'h0);
    check("rst_core_exp", 32'(core_exp), 32'd0);
    check("rst_special_data", special_data, 32'h0);
    rst_n = 1'b1;
    step();

    // Normal operands
    run_op(32'h4080_0000, 1'b0, 32'h0080_0000, 8'd128, 2, 1);
    run_op(32'h4000_0000, 1'b0, 32'h0100_0000, 8'd127, 2, 3);
    run_op(32'h3F80_0000, 1'b0, 32'h0080_0000, 8'd127, 2, 2);
    run_op(32'h3FC0_0000, 1'b0, 32'h00C0_0000, 8'd127, 2, 1);
    run_op(32'h7F7F_FFFF, 1'b0, 32'h01FF_FFFE, 8'd190, 2, 4);
    run_op(32'h0080_0000, 1'b0, 32'h0080_0000, 8'd64,  2, 1);

    // Special operands
    run_op(32'hC080_0000, 1'b1, 32'h7FC0_0000, 8'd0, 0, 0);
    run_op(32'h8000_0000, 1'b1, 32'h8000_0000, 8'd0, 0, 0);
    run_op(32'h0000_0000, 1'b1, 32'h0000_0000, 8'd0, 0, 0);
    run_op(32'h7F80_0000, 1'b1, 32'h7F80_0000, 8'd0, 0, 0);
    run_op(32'h7FA0_0000, 1'b1, 32'h7FC0_0000, 8'd0, 0, 0);
    run_op(32'hFF80_0000, 1'b1, 32'h7FC0_0000, 8'd0, 0, 0);

    // Denormals
`ifdef FP_SQRT_DENORM_EN
    run_op(32'h0000_0001, 1'b0, 32'h0100_0000, 8'd52, 3, 2);
    run_op(32'h0040_0000, 1'b0, 32'h0100_0000, 8'd63, 3, 1);
    run_op(32'h8000_0001, 1'b1, 32'h7FC0_0000, 8'd0, 0, 0);
`else
    run_op(32'h0000_0001, 1'b1, 32'h0000_0000, 8'd0, 0, 0);
    run_op(32'h0040_0000, 1'b1, 32'h0000_0000, 8'd0, 0, 0);
    run_op(32'h8000_0001, 1'b1, 32'h8000_0000, 8'd0, 0, 0);
`endif

    // core_done while idle must be ignored
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    check("idle_done_busy", 32'(busy), 32'd0);
    step();
    check("idle_done_busy2", 32'(busy), 32'd0);

    // in_valid held through the whole operation: exactly two captures
    base = accepts;
    sb_q.push_back('{1'b0, 32'h0080_0000, 8'd128, 2});
    sb_q.push_back('{1'b0, 32'h0100_0000, 8'd127, 2});
    in_valid = 1'b1;
    in_data  = 32'h4080_0000;
    step();
    in_data = 32'h4000_0000;
    wait_start("hold_start_a");
    repeat (3) begin
      step();
      check("hold_in_ready_low", 32'(in_ready), 32'd0);
    end
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    check("hold_ready_after_done", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    wait_start("hold_start_b");
    step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    step();
    check("hold_accept_count", 32'(accepts - base), 32'd2);

    // Reset while waiting for the core
    sb_q.push_back('{1'b0, 32'h0080_0000, 8'd128, 2});
    in_valid = 1'b1;
    in_data  = 32'h4080_0000;
    step();
    in_valid = 1'b0;
    wait_start("rst_wait_start");
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("wrst_busy", 32'(busy), 32'd0);
    check("wrst_core_start", 32'(core_start), 32'd0);
    check("wrst_in_ready", 32'(in_ready), 32'd1);
    check("wrst_core_data", core_data, 32'h0);
    check("wrst_core_exp", 32'(core_exp), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    repeat (4) begin
      step();
      check("post_rst_idle", 32'(busy), 32'd0);
    end

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fp_sqrt_prep
